// File: rtl/edge_row_cache.sv
// Multi-row edge-weight cache in front of a row-major adjacency matrix in graph memory.
// Misses fill a whole row one element at a time; replacement is invalid-first, then round-robin.
module edge_row_cache #(
  parameter int unsigned MAX_NODES   = 16,
  parameter int unsigned INDEX_WIDTH = 4,
  parameter int unsigned VALUE_WIDTH = 8,
  parameter int unsigned MADDR_WIDTH = 16,
  parameter int unsigned MDATA_WIDTH = 8,
  parameter int unsigned CACHE_ROWS  = 2,
  parameter int unsigned ELEM_BYTES  = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [MADDR_WIDTH-1:0] base_address,
  input  logic [INDEX_WIDTH:0]   number_of_nodes,
  input  logic                   query_valid,
  output logic                   query_ready,
  input  logic [INDEX_WIDTH-1:0] from_node,
  input  logic [INDEX_WIDTH-1:0] to_node,
  output logic [MADDR_WIDTH-1:0] mem_addr,
  output logic                   mem_read_enable,
  input  logic [MDATA_WIDTH-1:0] mem_data,
  input  logic                   mem_read_ready,
  output logic                   resp_valid,
  output logic [VALUE_WIDTH-1:0] edge_value,
  output logic                   resp_hit
);

  localparam int unsigned RowW = (CACHE_ROWS > 1) ? $clog2(CACHE_ROWS) : 1;
  localparam logic [INDEX_WIDTH:0] MaxDim = (INDEX_WIDTH + 1)'(MAX_NODES);

  typedef enum logic [1:0] {StIdle, StFill, StRespond} state_e;

  state_e                 state_q;
  logic [MADDR_WIDTH-1:0] base_q;
  logic [INDEX_WIDTH:0]   dim_q;
  logic [CACHE_ROWS-1:0]  valid_q;
  logic [INDEX_WIDTH-1:0] tag_q  [CACHE_ROWS];
  logic [VALUE_WIDTH-1:0] line_q [CACHE_ROWS][MAX_NODES];
  logic [RowW-1:0]        rr_q, victim_q;
  logic [INDEX_WIDTH-1:0] row_q, col_q, to_q;
  logic                   query_ready_q, mem_read_enable_q, resp_valid_q, resp_hit_q;
  logic [MADDR_WIDTH-1:0] mem_addr_q;
  logic [VALUE_WIDTH-1:0] edge_value_q;

  logic                   hit, free, accept, in_range, last_col;
  logic [RowW-1:0]        hit_idx, free_idx, victim, rr_next;
  logic [VALUE_WIDTH-1:0] mem_val;

  function automatic logic [MADDR_WIDTH-1:0] addr_of(input logic [INDEX_WIDTH-1:0] row,
                                                     input logic [INDEX_WIDTH-1:0] col);
    logic [MADDR_WIDTH-1:0] elem;
    elem = MADDR_WIDTH'(row) * MADDR_WIDTH'(dim_q) + MADDR_WIDTH'(col);
    return base_q + elem * MADDR_WIDTH'(ELEM_BYTES);
  endfunction

  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free     = 1'b0;
    free_idx = '0;
    // Descending scan so the lowest matching index wins.
    for (int i = CACHE_ROWS - 1; i >= 0; i--) begin
      if (valid_q[i] && tag_q[i] == from_node) begin
        hit     = 1'b1;
        hit_idx = RowW'(i);
      end
      if (!valid_q[i]) begin
        free     = 1'b1;
        free_idx = RowW'(i);
      end
    end
    victim   = free ? free_idx : rr_q;
    rr_next  = (rr_q == RowW'(CACHE_ROWS - 1)) ? '0 : rr_q + 1'b1;
    accept   = (state_q == StIdle) && query_valid && query_ready_q;
    in_range = ({1'b0, from_node} < dim_q) && ({1'b0, to_node} < dim_q);
    last_col = ({1'b0, col_q} == dim_q - (INDEX_WIDTH + 1)'(1));
    mem_val  = VALUE_WIDTH'(mem_data);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q           <= StIdle;
      base_q            <= base_address;
      dim_q             <= (number_of_nodes > MaxDim) ? MaxDim : number_of_nodes;
      valid_q           <= '0;
      rr_q              <= '0;
      victim_q          <= '0;
      row_q             <= '0;
      col_q             <= '0;
      to_q              <= '0;
      query_ready_q     <= 1'b0;
      mem_read_enable_q <= 1'b0;
      mem_addr_q        <= '0;
      resp_valid_q      <= 1'b0;
      edge_value_q      <= '0;
      resp_hit_q        <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          query_ready_q <= 1'b1;
          if (accept) begin
            query_ready_q <= 1'b0;
            row_q         <= from_node;
            to_q          <= to_node;
            if (!in_range) begin
              edge_value_q <= '1;
              resp_hit_q   <= 1'b0;
              resp_valid_q <= 1'b1;
              state_q      <= StRespond;
            end else if (hit) begin
              edge_value_q <= line_q[hit_idx][to_node];
              resp_hit_q   <= 1'b1;
              resp_valid_q <= 1'b1;
              state_q      <= StRespond;
            end else begin
              valid_q[victim]   <= 1'b0;
              victim_q          <= victim;
              if (!free) rr_q   <= rr_next;
              col_q             <= '0;
              mem_read_enable_q <= 1'b1;
              mem_addr_q        <= addr_of(from_node, '0);
              state_q           <= StFill;
            end
          end
        end
        StFill: begin
          if (mem_read_ready) begin
            if (last_col) begin
              valid_q[victim_q] <= 1'b1;
              tag_q[victim_q]   <= row_q;
              mem_read_enable_q <= 1'b0;
              // The requested entry may be the one arriving this very cycle.
              edge_value_q      <= (to_q == col_q) ? mem_val : line_q[victim_q][to_q];
              resp_hit_q        <= 1'b0;
              resp_valid_q      <= 1'b1;
              state_q           <= StRespond;
            end else begin
              col_q      <= col_q + 1'b1;
              mem_addr_q <= addr_of(row_q, col_q + 1'b1);
            end
          end
        end
        StRespond: begin
          query_ready_q <= 1'b1;
          state_q       <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && state_q == StFill && mem_read_ready) begin
      line_q[victim_q][col_q] <= mem_val;
    end
  end

  assign query_ready     = query_ready_q;
  assign mem_read_enable = mem_read_enable_q;
  assign mem_addr        = mem_addr_q;
  assign resp_valid      = resp_valid_q;
  assign edge_value      = edge_value_q;
  assign resp_hit        = resp_hit_q;

endmodule

// File: tb/tb_edge_row_cache.sv
// Directed bench for edge_row_cache; memory returns the low byte of the address with a
// programmable per-read wait.
module tb_edge_row_cache;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] base_address = 16'h0100;
  logic [4:0]  number_of_nodes = 5'd4;
  logic        query_valid = 1'b0;
  logic        query_ready;
  logic [3:0]  from_node = '0;
  logic [3:0]  to_node = '0;
  logic [15:0] mem_addr;
  logic        mem_read_enable;
  logic [7:0]  mem_data;
  logic        mem_read_ready;
  logic        resp_valid;
  logic [7:0]  edge_value;
  logic        resp_hit;

  int compared = 0;
  int mismatched = 0;

  int          mem_delay = 0;
  int          wait_cnt = 0;
  logic        spurious = 1'b0;
  logic [15:0] addr_log[$];
  int          en_cycles = 0;
  int          unstable = 0;
  logic        prev_wait = 1'b0;
  logic [15:0] prev_addr = '0;

  edge_row_cache dut (
    .clock          (clock),
    .reset          (reset),
    .base_address   (base_address),
    .number_of_nodes(number_of_nodes),
    .query_valid    (query_valid),
    .query_ready    (query_ready),
    .from_node      (from_node),
    .to_node        (to_node),
    .mem_addr       (mem_addr),
    .mem_read_enable(mem_read_enable),
    .mem_data       (mem_data),
    .mem_read_ready (mem_read_ready),
    .resp_valid     (resp_valid),
    .edge_value     (edge_value),
    .resp_hit       (resp_hit)
  );

  always #5 clock = ~clock;

  assign mem_data       = mem_addr[7:0];
  assign mem_read_ready = spurious | (mem_read_enable && (wait_cnt == mem_delay));

  always @(posedge clock) begin
    if (mem_read_enable && !mem_read_ready) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
    if (mem_read_enable && mem_read_ready) addr_log.push_back(mem_addr);
    if (mem_read_enable) en_cycles <= en_cycles + 1;
    if (prev_wait && mem_read_enable && mem_addr != prev_addr) unstable <= unstable + 1;
    prev_wait <= mem_read_enable && !mem_read_ready;
    prev_addr <= mem_addr;
  end

  task automatic do_reset(input logic [15:0] base, input logic [4:0] n);
    @(negedge clock);
    reset = 1'b1;
    base_address = base;
    number_of_nodes = n;
    query_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  // Issue a query and return once it has been accepted (at the following negedge).
  task automatic start_query(input logic [3:0] f, input logic [3:0] t);
    int n = 0;
    query_valid = 1'b1;
    from_node = f;
    to_node = t;
    while (!query_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!query_ready) begin
      $display("FAIL accept_timeout: query_ready=%b after %0d cycles, required 1", query_ready, n);
      mismatched++;
      compared++;
    end
    @(posedge clock);
    @(negedge clock);
    query_valid = 1'b0;
    from_node = ~f;
    to_node = ~t;
  endtask

  // Returns at the negedge on which resp_valid is seen; lat counts cycles after accept.
  task automatic run_query(input logic [3:0] f, input logic [3:0] t,
                           output logic [7:0] val, output logic hit, output int lat);
    start_query(f, t);
    lat = 1;
    while (!resp_valid && lat < 300) begin
      @(negedge clock);
      lat++;
    end
    if (!resp_valid) begin
      $display("FAIL resp_timeout: resp_valid=%b after %0d cycles, required 1", resp_valid, lat);
      mismatched++;
      compared++;
    end
    val = edge_value;
    hit = resp_hit;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    if ({query_ready, mem_read_enable, mem_addr, resp_valid, edge_value, resp_hit} !== '0) begin
      $display("FAIL reset_outputs: got rdy=%b en=%b addr=%h rv=%b val=%h hit=%b, required all 0",
               query_ready, mem_read_enable, mem_addr, resp_valid, edge_value, resp_hit);
      mismatched++;
    end
    compared++;
    reset = 1'b0;
    @(negedge clock);
    if (query_ready !== 1'b1) begin
      $display("FAIL ready_after_reset: got %b, required 1", query_ready);
      mismatched++;
    end
    compared++;
  endtask

  task automatic test_fill_miss();
    logic [7:0] v;
    logic h;
    int lat;
    int s = addr_log.size();
    run_query(4'd1, 4'd2, v, h, lat);
    if (addr_log.size() != s + 4) begin
      $display("FAIL fill_read_count: got %0d, required 4", addr_log.size() - s);
      mismatched++;
    end
    compared++;
    for (int i = 0; i < 4 && s + i < addr_log.size(); i++) begin
      if (addr_log[s+i] !== 16'h0104 + 16'(i)) begin
        $display("FAIL fill_addr%0d: got %h, required %h", i, addr_log[s+i], 16'h0104 + 16'(i));
        mismatched++;
      end
      compared++;
    end
    if ({v, h} !== {8'h06, 1'b0}) begin
      $display("FAIL fill_resp: got val=%h hit=%b, required val=06 hit=0", v, h);
      mismatched++;
    end
    compared++;
    @(negedge clock);
    if ({resp_valid, query_ready, edge_value} !== {1'b0, 1'b1, 8'h06}) begin
      $display("FAIL resp_pulse: got rv=%b rdy=%b val=%h, required rv=0 rdy=1 val=06",
               resp_valid, query_ready, edge_value);
      mismatched++;
    end
    compared++;
  endtask

  task automatic test_hit();
    logic [7:0] v;
    logic h;
    int lat;
    int e0 = en_cycles;
    run_query(4'd1, 4'd3, v, h, lat);
    if ({v, h} !== {8'h07, 1'b1} || lat != 1) begin
      $display("FAIL hit_resp: got val=%h hit=%b lat=%0d, required val=07 hit=1 lat=1", v, h, lat);
      mismatched++;
    end
    compared++;
    if (en_cycles != e0) begin
      $display("FAIL hit_no_mem: got %0d enable cycles, required 0", en_cycles - e0);
      mismatched++;
    end
    compared++;
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int bad = 0;
    @(negedge clock);
    query_valid = 1'b1;
    from_node = 4'd1;
    to_node = 4'd1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      if (resp_valid) begin
        pulses++;
        if (edge_value !== 8'h05 || resp_hit !== 1'b1) bad++;
      end
    end
    query_valid = 1'b0;
    if (pulses != 3 || bad != 0) begin
      $display("FAIL back_to_back: got %0d pulses (%0d wrong), required 3 pulses (0 wrong)",
               pulses, bad);
      mismatched++;
    end
    compared++;
  endtask

  task automatic test_replacement();
    logic [3:0] rows[6] = '{4'd0, 4'd2, 4'd3, 4'd2, 4'd0, 4'd2};
    logic [3:0] cols[6] = '{4'd1, 4'd3, 4'd0, 4'd2, 4'd3, 4'd1};
    logic [7:0] exp_v[6] = '{8'h01, 8'h0B, 8'h0C, 8'h0A, 8'h03, 8'h09};
    logic       exp_h[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] v;
    logic h;
    int lat;
    int s = 0;
    do_reset(16'h0100, 5'd4);
    for (int i = 0; i < 6; i++) begin
      if (i == 4) s = addr_log.size();
      run_query(rows[i], cols[i], v, h, lat);
      if ({v, h} !== {exp_v[i], exp_h[i]}) begin
        $display("FAIL replace%0d: got val=%h hit=%b, required val=%h hit=%b",
                 i, v, h, exp_v[i], exp_h[i]);
        mismatched++;
      end
      compared++;
      if (i == 4) begin
        if (addr_log.size() <= s || addr_log[s] !== 16'h0100) begin
          $display("FAIL refetch_addr: got %0d reads, first %h, required first 0100",
                   addr_log.size() - s, addr_log.size() > s ? addr_log[s] : 16'hxxxx);
          mismatched++;
        end
        compared++;
      end
    end
  endtask

  task automatic test_wait_and_reset();
    logic [7:0] v;
    logic h;
    int lat;
    int s;
    int u0;
    int n = 0;
    do_reset(16'h0100, 5'd4);
    mem_delay = 3;
    s = addr_log.size();
    u0 = unstable;
    run_query(4'd2, 4'd1, v, h, lat);
    if (addr_log.size() != s + 4 || {v, h} !== {8'h09, 1'b0} || unstable != u0) begin
      $display("FAIL wait_fill: got reads=%0d val=%h hit=%b unstable=%0d, required 4 09 0 0",
               addr_log.size() - s, v, h, unstable - u0);
      mismatched++;
    end
    compared++;
    for (int i = 0; i < 4 && s + i < addr_log.size(); i++) begin
      if (addr_log[s+i] !== 16'h0108 + 16'(i)) begin
        $display("FAIL wait_addr%0d: got %h, required %h", i, addr_log[s+i], 16'h0108 + 16'(i));
        mismatched++;
      end
      compared++;
    end
    // Abort a fill of row 3 partway through its second read.
    s = addr_log.size();
    start_query(4'd3, 4'd0);
    while (addr_log.size() < s + 1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    if (mem_read_enable !== 1'b1 || addr_log.size() != s + 1) begin
      $display("FAIL mid_fill: got en=%b reads=%0d, required en=1 reads=1",
               mem_read_enable, addr_log.size() - s);
      mismatched++;
    end
    compared++;
    reset = 1'b1;
    @(negedge clock);
    if (mem_read_enable !== 1'b0) begin
      $display("FAIL reset_abort_en: got %b, required 0", mem_read_enable);
      mismatched++;
    end
    compared++;
    spurious = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    spurious = 1'b0;
    mem_delay = 0;
    s = addr_log.size();
    run_query(4'd3, 4'd0, v, h, lat);
    if ({v, h} !== {8'h0C, 1'b0} || addr_log.size() != s + 4) begin
      $display("FAIL after_abort: got val=%h hit=%b reads=%0d, required val=0c hit=0 reads=4",
               v, h, addr_log.size() - s);
      mismatched++;
    end
    compared++;
  endtask

  task automatic test_out_of_range();
    logic [7:0] v;
    logic h;
    int lat;
    int e0;
    int s;
    do_reset(16'h0100, 5'd4);
    e0 = en_cycles;
    run_query(4'd4, 4'd0, v, h, lat);
    if ({v, h} !== {8'hFF, 1'b0} || lat != 1) begin
      $display("FAIL oor_row: got val=%h hit=%b lat=%0d, required ff 0 1", v, h, lat);
      mismatched++;
    end
    compared++;
    run_query(4'd0, 4'd5, v, h, lat);
    if ({v, h} !== {8'hFF, 1'b0} || lat != 1) begin
      $display("FAIL oor_col: got val=%h hit=%b lat=%0d, required ff 0 1", v, h, lat);
      mismatched++;
    end
    compared++;
    if (en_cycles != e0) begin
      $display("FAIL oor_no_mem: got %0d enable cycles, required 0", en_cycles - e0);
      mismatched++;
    end
    compared++;
    do_reset(16'h0100, 5'd20);
    s = addr_log.size();
    run_query(4'd15, 4'd15, v, h, lat);
    if (addr_log.size() != s + 16 || addr_log[addr_log.size()-1] !== 16'h01FF || h !== 1'b0) begin
      $display("FAIL clamp: got reads=%0d last=%h hit=%b, required 16 01ff 0",
               addr_log.size() - s, addr_log[addr_log.size()-1], h);
      mismatched++;
    end
    compared++;
    do_reset(16'h0100, 5'd0);
    e0 = en_cycles;
    run_query(4'd0, 4'd0, v, h, lat);
    if ({v, h} !== {8'hFF, 1'b0} || en_cycles != e0) begin
      $display("FAIL zero_dim: got val=%h hit=%b en=%0d, required ff 0 0", v, h, en_cycles - e0);
      mismatched++;
    end
    compared++;
  endtask

  task automatic test_wrap();
    logic [7:0] v;
    logic h;
    int lat;
    int s;
    do_reset(16'hFFFE, 5'd2);
    s = addr_log.size();
    run_query(4'd0, 4'd1, v, h, lat);
    if (addr_log.size() != s + 2 || addr_log[s] !== 16'hFFFE || addr_log[s+1] !== 16'hFFFF ||
        v !== 8'hFF) begin
      $display("FAIL wrap_row0: got reads=%0d val=%h, required FFFE,FFFF val=ff",
               addr_log.size() - s, v);
      mismatched++;
    end
    compared++;
    s = addr_log.size();
    run_query(4'd1, 4'd0, v, h, lat);
    if (addr_log.size() != s + 2 || addr_log[s] !== 16'h0000 || addr_log[s+1] !== 16'h0001 ||
        {v, h} !== {8'h00, 1'b0}) begin
      $display("FAIL wrap_row1: got reads=%0d val=%h hit=%b, required 0000,0001 val=00 hit=0",
               addr_log.size() - s, v, h);
      mismatched++;
    end
    compared++;
  endtask

  initial begin
    test_reset();
    test_fill_miss();
    test_hit();
    test_back_to_back();
    test_replacement();
    test_wait_and_reset();
    test_out_of_range();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
